// File: rtl/temporizador_pkg.sv
// -----------------------------------------------------------------------------
// temporizador_pkg
//   Definitions shared by the millisecond timers and the tick generator that
//   feeds them.
//
//   LARGURA_PADRAO : default width of the duration/remaining counters (ms)
//   TICKS_POR_MS   : clk cycles per 1 ms at 50 MHz (used by the generator)
//   estado_t       : timer state, 2-bit encoding
// -----------------------------------------------------------------------------
package temporizador_pkg;

    localparam int LARGURA_PADRAO = 16;
    localparam int TICKS_POR_MS   = 50000;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2
    } estado_t;

endpackage : temporizador_pkg

// File: rtl/temporizador_ms.sv
// -----------------------------------------------------------------------------
// temporizador_ms
//   Loadable millisecond countdown timer. Counts the external 1 ms strobe down
//   from a programmed duration and raises a 1-cycle pulse on expiry. Supports
//   start/restart, pause/resume toggle and cancel.
//
//   Optional build macro TEMPORIZADOR_AUTO_RELOAD_EN: periodic mode. On the
//   terminal tick the duration input is re-sampled and counting continues
//   (or stops if the new duration is 0). Without it the timer is one-shot.
//
// Ports
//   clk          in   system clock (50 MHz)
//   rst          in   synchronous reset, active-high
//   tick_1ms     in   1-cycle strobe per ms from the shared tick generator
//   iniciar      in   1-cycle: load duracao_ms and start (also restarts)
//   pausar       in   1-cycle: toggle counting <-> paused
//   cancelar     in   1-cycle: abort, no end pulse
//   duracao_ms   in   duration in ms, sampled on iniciar / auto-reload
//   restante_ms  out  remaining ms (registered)
//   ocupado      out  1 while counting or paused
//   pausado      out  1 while paused
//   fim          out  1-cycle expiry pulse
//
// Per-cycle command priority: cancelar > iniciar > pausar > tick_1ms.
// -----------------------------------------------------------------------------
module temporizador_ms
    import temporizador_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1ms,
    input  logic               iniciar,
    input  logic               pausar,
    input  logic               cancelar,
    input  logic [LARGURA-1:0] duracao_ms,
    output logic [LARGURA-1:0] restante_ms,
    output logic               ocupado,
    output logic               pausado,
    output logic               fim
);

    localparam logic [LARGURA-1:0] ZERO = '0;
    localparam logic [LARGURA-1:0] UM   = LARGURA'(1);

    estado_t            estado_q,   estado_d;
    logic [LARGURA-1:0] restante_q, restante_d;
    logic               fim_q,      fim_d;

    logic duracao_nula;
    assign duracao_nula = (duracao_ms == ZERO);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        estado_d   = estado_q;
        restante_d = restante_q;
        fim_d      = 1'b0;

        unique case (estado_q)
            OCIOSO: begin
                // pausar, cancelar and ticks have no effect while idle
                if (!cancelar && iniciar) begin
                    if (duracao_nula) begin
                        // zero-length timer expires immediately
                        fim_d      = 1'b1;
                        restante_d = ZERO;
                    end else begin
                        restante_d = duracao_ms;
                        estado_d   = CONTANDO;
                    end
                end
            end

            CONTANDO: begin
                if (cancelar) begin
                    estado_d   = OCIOSO;
                    restante_d = ZERO;
                end else if (iniciar) begin
                    // restart; a coincident tick is not counted
                    if (duracao_nula) begin
                        fim_d      = 1'b1;
                        estado_d   = OCIOSO;
                        restante_d = ZERO;
                    end else begin
                        restante_d = duracao_ms;
                    end
                end else if (pausar) begin
                    // a tick in the same cycle is dropped
                    estado_d = PAUSADO;
                end else if (tick_1ms) begin
                    if (restante_q > UM) begin
                        restante_d = restante_q - UM;
                    end else begin
                        // terminal tick; the "<= 1" test also keeps a
                        // hypothetical 0 from wrapping
                        fim_d = 1'b1;
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
                        if (duracao_nula) begin
                            estado_d   = OCIOSO;
                            restante_d = ZERO;
                        end else begin
                            restante_d = duracao_ms;
                        end
`else
                        estado_d   = OCIOSO;
                        restante_d = ZERO;
`endif
                    end
                end
            end

            PAUSADO: begin
                // ticks ignored, remaining time frozen
                if (cancelar) begin
                    estado_d   = OCIOSO;
                    restante_d = ZERO;
                end else if (iniciar) begin
                    if (duracao_nula) begin
                        fim_d      = 1'b1;
                        estado_d   = OCIOSO;
                        restante_d = ZERO;
                    end else begin
                        restante_d = duracao_ms;
                        estado_d   = CONTANDO;
                    end
                end else if (pausar) begin
                    estado_d = CONTANDO;
                end
            end

            default: begin
                estado_d   = OCIOSO;
                restante_d = ZERO;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers (reset aborts silently: no fim)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            restante_q <= ZERO;
            fim_q      <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            restante_q <= restante_d;
            fim_q      <= fim_d;
        end
    end

    assign restante_ms = restante_q;
    assign fim         = fim_q;
    assign ocupado     = (estado_q != OCIOSO);
    assign pausado     = (estado_q == PAUSADO);

endmodule : temporizador_ms

// File: tb/tb_temporizador_ms.sv
// -----------------------------------------------------------------------------
// tb_temporizador_ms
//   Self-checking bench for temporizador_ms. The reference keeps the loaded
//   duration and the number of ticks counted since the load; remaining time is
//   their difference. Directed scenarios first, then random commands.
// -----------------------------------------------------------------------------
module tb_temporizador_ms;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, tick_1ms, iniciar, pausar, cancelar;
    logic [W-1:0] duracao_ms;
    logic [W-1:0] restante_ms;
    logic         ocupado, pausado, fim;

    always #10 clk = ~clk;

    temporizador_ms #(.LARGURA(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1ms    (tick_1ms),
        .iniciar     (iniciar),
        .pausar      (pausar),
        .cancelar    (cancelar),
        .duracao_ms  (duracao_ms),
        .restante_ms (restante_ms),
        .ocupado     (ocupado),
        .pausado     (pausado),
        .fim         (fim)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_fim  = 0;

    // reference: busy/paused flags, loaded duration, ticks counted since load
    bit m_busy, m_paused, m_fim;
    int m_dur, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_rest();
        return m_busy ? (m_dur - m_cnt) : 0;
    endfunction

    task automatic model(input bit r, input bit t, input bit i, input bit p,
                         input bit c, input int d);
        m_fim = 1'b0;
        if (r) begin
            m_busy = 0; m_paused = 0; m_dur = 0; m_cnt = 0;
        end else if (c) begin
            m_busy = 0; m_paused = 0;
        end else if (i) begin
            if (d == 0) begin
                m_fim = 1'b1; m_busy = 0; m_paused = 0;
            end else begin
                m_busy = 1; m_paused = 0; m_dur = d; m_cnt = 0;
            end
        end else if (p) begin
            if (m_busy) m_paused = !m_paused;
        end else if (t && m_busy && !m_paused) begin
            m_cnt++;
            if (m_cnt >= m_dur) begin
                m_fim = 1'b1;
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
                if (d != 0) begin m_dur = d; m_cnt = 0; end
                else m_busy = 0;
`else
                m_busy = 0;
`endif
            end
        end
    endtask

    // one clock: drive, edge, update reference, check all outputs
    task automatic cyc(input bit r, input bit t, input bit i, input bit p, input bit c);
        rst = r; tick_1ms = t; iniciar = i; pausar = p; cancelar = c;
        @(posedge clk);
        model(r, t, i, p, c, int'(duracao_ms));
        #1;
        chk("restante_ms", 32'(restante_ms), 32'(m_rest()));
        chk("ocupado",     32'(ocupado),     32'(m_busy));
        chk("pausado",     32'(pausado),     32'(m_busy && m_paused));
        chk("fim",         32'(fim),         32'(m_fim));
        if (fim) n_fim++;
        rst = 0; tick_1ms = 0; iniciar = 0; pausar = 0; cancelar = 0;
    endtask

    // n ticks, one every 5 clk
    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (4) cyc(0, 0, 0, 0, 0);
            cyc(0, 1, 0, 0, 0);
        end
    endtask

    int fim_antes;

    initial begin
        rst = 1; tick_1ms = 0; iniciar = 0; pausar = 0; cancelar = 0;
        duracao_ms = '0;
        m_busy = 0; m_paused = 0; m_dur = 0; m_cnt = 0; m_fim = 0;

        // reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("reset_restante", 32'(restante_ms), 32'd0);
        chk("reset_ocupado",  32'(ocupado),     32'd0);

        // 1: basic countdown 3,2,1,0
        duracao_ms = 3;
        cyc(0, 0, 1, 0, 0);
        chk("t1_load", 32'(restante_ms), 32'd3);
        ticks(1); chk("t1_r2", 32'(restante_ms), 32'd2);
        ticks(1); chk("t1_r1", 32'(restante_ms), 32'd1);
        ticks(1);
        chk("t1_r0",      32'(restante_ms), 32'd0);
        chk("t1_fim",     32'(fim),         32'd1);
        chk("t1_ocupado", 32'(ocupado),     32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t1_fim_1cyc", 32'(fim), 32'd0);

        // 2: pause holds, resume finishes with a single fim
        duracao_ms = 5;
        fim_antes = n_fim;
        cyc(0, 0, 1, 0, 0);
        ticks(2);
        cyc(0, 1, 0, 1, 0);          // tick coincident with pausar is dropped
        ticks(4);
        chk("t2_hold",    32'(restante_ms), 32'd3);
        chk("t2_pausado", 32'(pausado),     32'd1);
        cyc(0, 0, 0, 1, 0);
        ticks(3);
        chk("t2_fim_count", 32'(n_fim - fim_antes), 32'd1);

        // 3: cancel, then cancel+iniciar in the same cycle
        duracao_ms = 10;
        fim_antes = n_fim;
        cyc(0, 0, 1, 0, 0);
        ticks(4);
        cyc(0, 0, 0, 0, 1);
        chk("t3_rest", 32'(restante_ms), 32'd0);
        chk("t3_ocup", 32'(ocupado),     32'd0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1);
        chk("t3_cancel_wins", 32'(ocupado), 32'd0);
        ticks(2);
        chk("t3_no_fim", 32'(n_fim - fim_antes), 32'd0);

        // 4: zero duration; iniciar with coincident tick
        duracao_ms = 0;
        cyc(0, 0, 1, 0, 0);
        chk("t4_fim0",  32'(fim),     32'd1);
        chk("t4_ocup0", 32'(ocupado), 32'd0);
        duracao_ms = 2;
        cyc(0, 1, 1, 0, 0);
        chk("t4_tick_ignored", 32'(restante_ms), 32'd2);
        ticks(1);
        chk("t4_first_dec", 32'(restante_ms), 32'd1);
        ticks(1);

        // 5: reset mid-count at 7, then restart
        duracao_ms = 9;
        cyc(0, 0, 1, 0, 0);
        ticks(2);
        chk("t5_at7", 32'(restante_ms), 32'd7);
        fim_antes = n_fim;
        cyc(1, 0, 0, 0, 0);
        chk("t5_rst_rest", 32'(restante_ms), 32'd0);
        chk("t5_rst_ocup", 32'(ocupado),     32'd0);
        chk("t5_rst_fim",  32'(n_fim - fim_antes), 32'd0);
        duracao_ms = 2;
        cyc(0, 0, 1, 0, 0);
        ticks(2);
        chk("t5_restart_fim", 32'(n_fim - fim_antes), 32'd1);

`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
        // 6: periodic mode
        duracao_ms = 2;
        fim_antes = n_fim;
        cyc(0, 0, 1, 0, 0);
        ticks(6);
        chk("t6_periodic_fims", 32'(n_fim - fim_antes), 32'd3);
        chk("t6_ocupado",       32'(ocupado),           32'd1);
        duracao_ms = 0;
        ticks(2);
        chk("t6_stop", 32'(ocupado), 32'd0);
        cyc(0, 0, 0, 0, 0);
`endif

        // random phase against the reference
        for (int k = 0; k < 4000; k++) begin
            bit r, t, i, p, c;
            if ($urandom_range(0, 19) == 0)
                duracao_ms = W'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 8));
            r = ($urandom_range(0, 299) == 0);
            t = ($urandom_range(0, 4)   == 0);
            i = ($urandom_range(0, 39)  == 0);
            p = ($urandom_range(0, 39)  == 0);
            c = ($urandom_range(0, 79)  == 0);
            cyc(r, t, i, p, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_temporizador_ms
